// File: rtl/slice_pkg.sv
// Shared definitions for the slice packer: default geometry and the
// two-state controller encoding.
package slice_pkg;

  localparam int SLICE_W_DEFAULT  = 10;
  localparam int N_SLICES_DEFAULT = 48;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/slice_packer.sv
// Slice packer: gathers SLICE_W-bit slices into one frame of N_SLICES slices
// (slice 0 at the LSBs) and presents it with a valid/ready handshake. A flush
// closes a partial frame early; unwritten positions read as zero.
// All state is kept in three copies and majority-voted so that a single upset
// copy is outvoted. TMR = 0 uses only copy 0.
module slice_packer
  import slice_pkg::*;
#(
  parameter int SLICE_W  = SLICE_W_DEFAULT,
  parameter int N_SLICES = N_SLICES_DEFAULT,
  parameter bit TMR      = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [SLICE_W-1:0]             in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           flush,
  output logic [SLICE_W*N_SLICES-1:0]    out_data,
  output logic [$clog2(N_SLICES+1)-1:0]  out_nslices,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int DATA_W = SLICE_W * N_SLICES;
  localparam int CNT_W  = $clog2(N_SLICES + 1);
  localparam int COPIES = 3;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SLICES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_SLICES);

  // Redundant register copies
  state_t             r_state   [COPIES];
  logic [CNT_W-1:0]   r_cnt     [COPIES];
  logic [DATA_W-1:0]  r_data    [COPIES];
  logic [CNT_W-1:0]   r_nslices [COPIES];

  // Voted view of the state
  state_t             w_state;
  logic [CNT_W-1:0]   w_cnt;
  logic [DATA_W-1:0]  w_data;
  logic [CNT_W-1:0]   w_nslices;

  // Next-state values shared by all copies
  state_t             w_stateNext;
  logic [CNT_W-1:0]   w_cntNext;
  logic [DATA_W-1:0]  w_dataNext;
  logic [CNT_W-1:0]   w_nslicesNext;

  logic               w_accept;

  assign w_state = TMR ? state_t'((r_state[0] & r_state[1]) |
                                  (r_state[0] & r_state[2]) |
                                  (r_state[1] & r_state[2]))
                       : r_state[0];

  assign w_cnt = TMR ? ((r_cnt[0] & r_cnt[1]) |
                        (r_cnt[0] & r_cnt[2]) |
                        (r_cnt[1] & r_cnt[2]))
                     : r_cnt[0];

  assign w_data = TMR ? ((r_data[0] & r_data[1]) |
                         (r_data[0] & r_data[2]) |
                         (r_data[1] & r_data[2]))
                      : r_data[0];

  assign w_nslices = TMR ? ((r_nslices[0] & r_nslices[1]) |
                            (r_nslices[0] & r_nslices[2]) |
                            (r_nslices[1] & r_nslices[2]))
                         : r_nslices[0];

  // A held frame only frees the input when it is being taken this cycle, so
  // the incoming slice can become slice 0 of the next frame without a bubble.
  assign in_ready    = rst_n && ((w_state == FILL) || out_ready);
  assign w_accept    = in_valid && in_ready;

  assign out_valid   = (w_state == HOLD);
  assign out_data    = w_data;
  assign out_nslices = w_nslices;

  // Next-state logic: slice placement, frame closing and frame release
  always_comb begin
    w_stateNext   = w_state;
    w_cntNext     = w_cnt;
    w_dataNext    = w_data;
    w_nslicesNext = w_nslices;

    case (w_state)
      FILL: begin
        if (w_accept) begin
          w_dataNext[int'(w_cnt)*SLICE_W +: SLICE_W] = in_data;
          if (w_cnt == LAST_IDX) begin
            // A full frame closes itself; a coincident flush adds nothing.
            w_stateNext   = HOLD;
            w_nslicesNext = FULL_CNT;
            w_cntNext     = '0;
          end else if (flush) begin
            w_stateNext   = HOLD;
            w_nslicesNext = w_cnt + 1'b1;
            w_cntNext     = '0;
          end else begin
            w_cntNext     = w_cnt + 1'b1;
          end
        end else if (flush && (w_cnt != '0)) begin
          w_stateNext   = HOLD;
          w_nslicesNext = w_cnt;
          w_cntNext     = '0;
        end
      end

      HOLD: begin
        if (out_ready) begin
          w_stateNext   = FILL;
          w_dataNext    = '0;
          w_nslicesNext = '0;
          w_cntNext     = '0;
          if (w_accept) begin
            w_dataNext[SLICE_W-1:0] = in_data;
            if (N_SLICES == 1) begin
              w_stateNext   = HOLD;
              w_nslicesNext = FULL_CNT;
            end else begin
              w_cntNext     = CNT_W'(1);
            end
          end
        end
      end

      default: begin
        w_stateNext = FILL;
      end
    endcase
  end

  // State registers: every copy loads the same voted next value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < COPIES; i++) begin
        r_state[i]   <= FILL;
        r_cnt[i]     <= '0;
        r_data[i]    <= '0;
        r_nslices[i] <= '0;
      end
    end else begin
      for (int i = 0; i < COPIES; i++) begin
        r_state[i]   <= w_stateNext;
        r_cnt[i]     <= w_cntNext;
        r_data[i]    <= w_dataNext;
        r_nslices[i] <= w_nslicesNext;
      end
    end
  end

endmodule

// File: tb/tb_slice_packer.sv
// Directed testbench for slice_packer: full frames, flushed partial frames,
// output backpressure, flush corner cases and mid-frame reset.
module tb_slice_packer;
  import slice_pkg::*;

  localparam int SW = 10;
  localparam int NS = 48;
  localparam int DW = SW * NS;
  localparam int NW = $clog2(NS + 1);

  logic          clk;
  logic          rst_n;
  logic [SW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic [DW-1:0] out_data;
  logic [NW-1:0] out_nslices;
  logic          out_valid;
  logic          out_ready;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] expFrame;

  slice_packer #(
    .SLICE_W  (SW),
    .N_SLICES (NS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .out_data    (out_data),
    .out_nslices (out_nslices),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a stuck run
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [SW-1:0] d,
                               input logic f, input logic r);
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = r;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] comparison %s did not hold", tag);
    end
  endtask

  // Directed sequence
  initial begin
    rst_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    tick();
    tick();

    // Reset state
    checkOutput("rst_in_ready",  DW'(in_ready),    DW'(0));
    checkOutput("rst_out_valid", DW'(out_valid),   DW'(0));
    checkOutput("rst_out_data",  out_data,         DW'(0));
    checkOutput("rst_nslices",   DW'(out_nslices), DW'(0));
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", DW'(in_ready), DW'(1));

    // Back-to-back full frame, slice k = k
    expFrame = '0;
    for (int k = 0; k < NS; k++) begin
      applyStimulus(1'b1, SW'(k), 1'b0, 1'b1);
      expFrame[k*SW +: SW] = SW'(k);
      tick();
      if (k == NS - 2) checkOutput("full_not_early", DW'(out_valid), DW'(0));
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("full_valid",   DW'(out_valid),   DW'(1));
    checkOutput("full_nslices", DW'(out_nslices), DW'(48));
    checkOutput("full_data",    out_data,         expFrame);
    tick();
    checkOutput("full_one_frame", DW'(out_valid), DW'(0));
    checkOutput("full_cleared",   out_data,       DW'(0));

    // Five all-ones slices then flush
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 10'h3FF, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    tick();
    expFrame = {{(DW-50){1'b0}}, {50{1'b1}}};
    checkOutput("flush5_valid",   DW'(out_valid),   DW'(1));
    checkOutput("flush5_nslices", DW'(out_nslices), DW'(5));
    checkOutput("flush5_data",    out_data,         expFrame);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    tick();
    checkOutput("flush5_released", DW'(out_valid), DW'(0));

    // Full frame held under backpressure, then released with a new slice
    expFrame = '0;
    for (int k = 0; k < NS; k++) begin
      applyStimulus(1'b1, SW'(k + 100), 1'b0, 1'b0);
      expFrame[k*SW +: SW] = SW'(k + 100);
      tick();
    end
    applyStimulus(1'b1, 10'h155, 1'b0, 1'b0);
    #1;
    checkOutput("hold_in_ready", DW'(in_ready), DW'(0));
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, 10'h155, (c % 2) == 1, 1'b0);
      tick();
      checkOutput("hold_stable_data", out_data, expFrame);
    end
    checkOutput("hold_in_ready_end", DW'(in_ready),    DW'(0));
    checkOutput("hold_nslices",      DW'(out_nslices), DW'(48));
    checkOutput("hold_valid",        DW'(out_valid),   DW'(1));
    applyStimulus(1'b1, 10'h155, 1'b0, 1'b1);
    tick();
    expFrame = DW'(10'h155);
    checkOutput("release_valid", DW'(out_valid), DW'(0));
    checkOutput("release_slice0", out_data,      expFrame);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    tick();
    checkOutput("release_frame_valid",   DW'(out_valid),   DW'(1));
    checkOutput("release_frame_nslices", DW'(out_nslices), DW'(1));
    checkOutput("release_frame_data",    out_data,         expFrame);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    tick();

    // Flush together with an accepted slice mid-frame
    applyStimulus(1'b1, 10'd1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 10'd2, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 10'd3, 1'b1, 1'b0);
    tick();
    expFrame = DW'({10'd3, 10'd2, 10'd1});
    checkOutput("flushacc_nslices", DW'(out_nslices), DW'(3));
    checkOutput("flushacc_data",    out_data,         expFrame);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    tick();

    // Flush coincident with the last slice: exactly one full frame
    expFrame = '0;
    for (int k = 0; k < NS; k++) begin
      applyStimulus(1'b1, SW'(k), (k == NS - 1), 1'b0);
      expFrame[k*SW +: SW] = SW'(k);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("lastflush_valid",   DW'(out_valid),   DW'(1));
    checkOutput("lastflush_nslices", DW'(out_nslices), DW'(48));
    checkOutput("lastflush_data",    out_data,         expFrame);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    tick();
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("lastflush_no_extra", DW'(out_valid), DW'(0));
    end

    // Flush with an empty frame is ignored
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    tick();
    checkOutput("emptyflush_none", DW'(out_valid), DW'(0));
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    tick();
    checkOutput("emptyflush_none2", DW'(out_valid), DW'(0));
    applyStimulus(1'b1, 10'h2A, 1'b1, 1'b0);
    tick();
    checkOutput("emptyflush_next_nslices", DW'(out_nslices), DW'(1));
    checkOutput("emptyflush_next_data",    out_data,         DW'(10'h2A));
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    tick();

    // Reset in the middle of a frame
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 10'h3FF, 1'b0, 1'b0);
      tick();
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready",  DW'(in_ready),    DW'(0));
    checkOutput("midrst_out_valid", DW'(out_valid),   DW'(0));
    checkOutput("midrst_out_data",  out_data,         DW'(0));
    checkOutput("midrst_nslices",   DW'(out_nslices), DW'(0));
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    expFrame = '0;
    for (int k = 0; k < NS; k++) begin
      applyStimulus(1'b1, SW'(k * 7 + 3), 1'b0, 1'b0);
      expFrame[k*SW +: SW] = SW'(k * 7 + 3);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("afterrst_valid",   DW'(out_valid),   DW'(1));
    checkOutput("afterrst_nslices", DW'(out_nslices), DW'(48));
    checkOutput("afterrst_data",    out_data,         expFrame);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    tick();
    checkOutput("afterrst_released", DW'(out_valid), DW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
